// File: rtl/car_display_pkg.sv
// Shared constants for the car display: segment encodings, scan FSM states
// and the default scan divider.
package car_display_pkg;

    localparam int unsigned SCAN_DIV_DEFAULT = 100000;
    localparam int unsigned NUM_DIGITS       = 4;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned SEG_W            = 8;

    // Segment order is {a,b,c,d,e,f,g,dp}, active high.
    localparam logic [SEG_W-1:0] SEG_0     = 8'b11111100;
    localparam logic [SEG_W-1:0] SEG_1     = 8'b01100000;
    localparam logic [SEG_W-1:0] SEG_2     = 8'b11011010;
    localparam logic [SEG_W-1:0] SEG_3     = 8'b11110010;
    localparam logic [SEG_W-1:0] SEG_4     = 8'b01100110;
    localparam logic [SEG_W-1:0] SEG_5     = 8'b10110110;
    localparam logic [SEG_W-1:0] SEG_6     = 8'b10111110;
    localparam logic [SEG_W-1:0] SEG_7     = 8'b11100000;
    localparam logic [SEG_W-1:0] SEG_8     = 8'b11111110;
    localparam logic [SEG_W-1:0] SEG_9     = 8'b11110110;
    localparam logic [SEG_W-1:0] SEG_DASH  = 8'b00000010;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'b00000000;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_e;

    // One-hot digit select for a scan state.
    function automatic logic [NUM_DIGITS-1:0] state_onehot(input scan_state_e s);
        return NUM_DIGITS'(1) << s;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to 7-segment decoder with blanking; values 10..15
// show a dash to flag invalid BCD.
module bcd_to_seg
    import car_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble_i,
    input  logic               blank_i,
    output logic [SEG_W-1:0]   seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/mileage_display.sv
// Four-digit multiplexed mileage display: prescaled digit scan, frame-aligned
// snapshot of the mileage, leading-zero blanking and registered outputs.
module mileage_display
    import car_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]  mile,
    input  logic                           enable,
    output logic [NUM_DIGITS-1:0]          seg_en,
    output logic [SEG_W-1:0]               seg_out
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam int unsigned SNAP_W = NUM_DIGITS * DIGIT_W;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    scan_state_e           state_q, state_d;
    logic [SNAP_W-1:0]     snap_q, snap_d;
    logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
    logic [SEG_W-1:0]      seg_out_q, seg_out_d;

    logic                  tick;
    logic [DIGIT_W-1:0]    cur_nibble;
    logic                  cur_blank;
    logic [SEG_W-1:0]      cur_seg;

    assign tick = (cnt_q == CNT_MAX);

    // Digit mux; a digit blanks only when it and every higher digit are zero.
    always_comb begin
        cur_nibble = snap_q[3:0];
        cur_blank  = 1'b0;
        unique case (state_q)
            DIG0: begin
                cur_nibble = snap_q[3:0];
                cur_blank  = 1'b0;
            end
            DIG1: begin
                cur_nibble = snap_q[7:4];
                cur_blank  = (snap_q[15:4] == 12'd0);
            end
            DIG2: begin
                cur_nibble = snap_q[11:8];
                cur_blank  = (snap_q[15:8] == 8'd0);
            end
            DIG3: begin
                cur_nibble = snap_q[15:12];
                cur_blank  = (snap_q[15:12] == 4'd0);
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble_i (cur_nibble),
        .blank_i  (cur_blank),
        .seg_o    (cur_seg)
    );

    // Next-state: prescaler, scan FSM, frame-boundary snapshot, output image.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = state_q;
        snap_d    = snap_q;
        seg_en_d  = '0;
        seg_out_d = '0;

        if (tick) begin
            cnt_d = '0;
            unique case (state_q)
                DIG0: state_d = DIG1;
                DIG1: state_d = DIG2;
                DIG2: state_d = DIG3;
                DIG3: state_d = DIG0;
            endcase
            if (state_q == DIG3) begin
                snap_d = mile;
            end
        end

        if (enable) begin
            seg_en_d  = state_onehot(state_q);
            seg_out_d = cur_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            state_q   <= DIG0;
            snap_q    <= '0;
            seg_en_q  <= '0;
            seg_out_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            snap_q    <= snap_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_mileage_display.sv
// Scoreboard bench for mileage_display: expected display events are queued up
// front and a negedge monitor pops one on every change of {seg_en, seg_out}.
module tb_mileage_display;

    typedef struct packed {
        logic [3:0] en;
        logic [7:0] seg;
        logic [7:0] hold;   // clocks this image stays up; 0 = not checked
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] mile;
    logic [3:0]  seg_en, seg_en1;
    logic [7:0]  seg_out, seg_out1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic mon1_on = 1'b0;
    logic chk_now = 1'b0;
    logic done    = 1'b0;

    logic [3:0] p0_en = '0, p1_en = '0;
    logic [7:0] p0_seg = '0, p1_seg = '0;
    int         h0 = 0, h1 = 0;
    int         ch0 = 0, ch1 = 0;
    exp_t       e;

    mileage_display #(.SCAN_DIV(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .mile    (mile),
        .enable  (enable),
        .seg_en  (seg_en),
        .seg_out (seg_out)
    );

    mileage_display #(.SCAN_DIV(1)) dut1 (
        .clk     (clk),
        .reset   (reset),
        .mile    (mile),
        .enable  (enable),
        .seg_en  (seg_en1),
        .seg_out (seg_out1)
    );

    always #5 clk = ~clk;

    task automatic push0(input logic [3:0] en, input logic [7:0] seg, input logic [7:0] hold);
        exp_t x;
        x.en = en; x.seg = seg; x.hold = hold;
        q0.push_back(x);
    endtask

    task automatic push1(input logic [3:0] en, input logic [7:0] seg, input logic [7:0] hold);
        exp_t x;
        x.en = en; x.seg = seg; x.hold = hold;
        q1.push_back(x);
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Checker: clk high means the async-reset probe fired mid-cycle.
    always @(negedge clk or posedge chk_now) begin
        if (clk) begin
            n_vec++;
            if (seg_en !== 4'd0 || seg_out !== 8'd0 || seg_en1 !== 4'd0 || seg_out1 !== 8'd0) begin
                n_err++;
                $display("FAIL reset_async: got en=%b seg=%b en1=%b seg1=%b, want all zero",
                         seg_en, seg_out, seg_en1, seg_out1);
            end
        end else begin
            if ({seg_en, seg_out} !== {p0_en, p0_seg}) begin
                if (ch0 != 0) begin
                    n_vec++;
                    if (h0 != ch0) begin
                        n_err++;
                        $display("FAIL hold_div4: en=%b held %0d clks, want %0d", p0_en, h0, ch0);
                    end
                end
                n_vec++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_div4: got en=%b seg=%b, want no change", seg_en, seg_out);
                    ch0 = 0;
                end else begin
                    e = q0.pop_front();
                    if (seg_en !== e.en || seg_out !== e.seg) begin
                        n_err++;
                        $display("FAIL event_div4: got en=%b seg=%b, want en=%b seg=%b",
                                 seg_en, seg_out, e.en, e.seg);
                    end
                    ch0 = int'(e.hold);
                end
                h0 = 1;
                p0_en = seg_en;
                p0_seg = seg_out;
            end else begin
                h0++;
            end

            if (!mon1_on) begin
                ch1 = 0;
                h1 = 0;
            end else if ({seg_en1, seg_out1} !== {p1_en, p1_seg}) begin
                if (ch1 != 0) begin
                    n_vec++;
                    if (h1 != ch1) begin
                        n_err++;
                        $display("FAIL hold_div1: en=%b held %0d clks, want %0d", p1_en, h1, ch1);
                    end
                end
                n_vec++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_div1: got en=%b seg=%b, want no change", seg_en1, seg_out1);
                    ch1 = 0;
                end else begin
                    e = q1.pop_front();
                    if (seg_en1 !== e.en || seg_out1 !== e.seg) begin
                        n_err++;
                        $display("FAIL event_div1: got en=%b seg=%b, want en=%b seg=%b",
                                 seg_en1, seg_out1, e.en, e.seg);
                    end
                    ch1 = int'(e.hold);
                end
                h1 = 1;
            end else begin
                h1++;
            end
            p1_en = seg_en1;
            p1_seg = seg_out1;

            if (done) begin
                n_vec++;
                if (q0.size() != 0) begin
                    n_err++;
                    $display("FAIL drain_div4: %0d events left, want 0", q0.size());
                end
                n_vec++;
                if (q1.size() != 0) begin
                    n_err++;
                    $display("FAIL drain_div1: %0d events left, want 0", q1.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
                $finish;
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        mile   = 16'h0000;

        // frame 0: snapshot is zero -> "0" and three blanks
        push0(4'b0001, 8'b11111100, 8'd4);
        push0(4'b0010, 8'b00000000, 8'd4);
        push0(4'b0100, 8'b00000000, 8'd4);
        push0(4'b1000, 8'b00000000, 8'd4);
        // frame 1: 0507
        push0(4'b0001, 8'b11100000, 8'd4);
        push0(4'b0010, 8'b11111100, 8'd4);
        push0(4'b0100, 8'b10110110, 8'd4);
        push0(4'b1000, 8'b00000000, 8'd4);
        // frame 2: 1234 (mile moves to 9999 during DIG1, must not tear)
        push0(4'b0001, 8'b01100110, 8'd4);
        push0(4'b0010, 8'b11110010, 8'd4);
        push0(4'b0100, 8'b11011010, 8'd4);
        push0(4'b1000, 8'b01100000, 8'd4);
        // frame 3: 9999
        push0(4'b0001, 8'b11110110, 8'd4);
        push0(4'b0010, 8'b11110110, 8'd4);
        push0(4'b0100, 8'b11110110, 8'd4);
        push0(4'b1000, 8'b11110110, 8'd4);
        // frame 4: 00A3
        push0(4'b0001, 8'b11110010, 8'd4);
        push0(4'b0010, 8'b00000010, 8'd4);
        push0(4'b0100, 8'b00000000, 8'd4);
        push0(4'b1000, 8'b00000000, 8'd4);
        // frame 5: 00A3, enable dropped one clk into DIG2 for 10 clks
        push0(4'b0001, 8'b11110010, 8'd4);
        push0(4'b0010, 8'b00000010, 8'd4);
        push0(4'b0100, 8'b00000000, 8'd1);
        push0(4'b0000, 8'b00000000, 8'd10);
        // frame 6: 5060, resumes at the tail of DIG0, reset one clk into DIG3
        push0(4'b0001, 8'b11111100, 8'd1);
        push0(4'b0010, 8'b10111110, 8'd4);
        push0(4'b0100, 8'b11111100, 8'd4);
        push0(4'b1000, 8'b10110110, 8'd1);
        push0(4'b0000, 8'b00000000, 8'd0);
        // after reset: zero frame, then 5060
        push0(4'b0001, 8'b11111100, 8'd4);
        push0(4'b0010, 8'b00000000, 8'd4);
        push0(4'b0100, 8'b00000000, 8'd4);
        push0(4'b1000, 8'b00000000, 8'd4);
        push0(4'b0001, 8'b11111100, 8'd4);
        push0(4'b0010, 8'b10111110, 8'd4);
        push0(4'b0100, 8'b11111100, 8'd4);
        push0(4'b1000, 8'b10110110, 8'd4);
        push0(4'b0001, 8'b11111100, 8'd0);

        // SCAN_DIV=1 after the final reset: one digit per clk
        push1(4'b0001, 8'b11111100, 8'd1);
        push1(4'b0010, 8'b00000000, 8'd1);
        push1(4'b0100, 8'b00000000, 8'd1);
        push1(4'b1000, 8'b00000000, 8'd1);
        push1(4'b0001, 8'b11111100, 8'd1);
        push1(4'b0010, 8'b10111110, 8'd1);
        push1(4'b0100, 8'b11111100, 8'd1);
        push1(4'b1000, 8'b10110110, 8'd0);

        adv(3);
        reset = 1'b0;           // t=0
        adv(1);  mile = 16'h0507;   // t=1
        adv(19); mile = 16'h1234;   // t=20
        adv(17); mile = 16'h9999;   // t=37, DIG1 of frame 2
        adv(13); mile = 16'h00A3;   // t=50
        adv(32); mile = 16'h5060;   // t=82
        adv(7);  enable = 1'b0;     // t=89, DIG2 of frame 5
        adv(10); enable = 1'b1;     // t=99
        adv(11);                    // t=110, DIG3 of frame 6
        reset = 1'b1;
        #1 chk_now = 1'b1;
        #1 chk_now = 1'b0;
        adv(2);
        reset   = 1'b0;
        mon1_on = 1'b1;
        adv(9);
        mon1_on = 1'b0;
        adv(26);
        done = 1'b1;
    end

endmodule
